// File: rtl/univ_shift_reg.sv
// Universal shift register: single-step shift/rotate/load/clear while idle,
// plus a counted burst mode that repeats one latched operation shamt times.
module univ_shift_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             d_in,
    input  logic [WIDTH-1:0] p_in,
    input  logic             start,
    input  logic [CNT_W-1:0] shamt,
    output logic [WIDTH-1:0] d_out,
    output logic             s_out,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SHL  = 3'b001;
    localparam logic [2:0] M_SHR  = 3'b010;
    localparam logic [2:0] M_ROL  = 3'b011;
    localparam logic [2:0] M_ROR  = 3'b100;
    localparam logic [2:0] M_LOAD = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         mode_q, mode_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               s_q, s_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               do_step;
    logic [2:0]         step_mode;

    // Sequencing: decides whether a step happens this edge and which mode it uses.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        do_step   = 1'b0;
        step_mode = mode;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (shamt != '0) begin
                        mode_d  = mode;
                        cnt_d   = shamt;
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end else if (en) begin
                    do_step = 1'b1;
                end
            end
            RUN: begin
                do_step   = 1'b1;
                step_mode = mode_q;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // One step of the selected operation; s_out only moves on shift/rotate.
    always_comb begin
        data_d = data_q;
        s_d    = s_q;
        if (do_step) begin
            case (step_mode)
                M_HOLD: data_d = data_q;
                M_SHL: begin
                    data_d = {data_q[WIDTH-2:0], d_in};
                    s_d    = data_q[WIDTH-1];
                end
                M_SHR: begin
                    data_d = {d_in, data_q[WIDTH-1:1]};
                    s_d    = data_q[0];
                end
                M_ROL: begin
                    data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                    s_d    = data_q[WIDTH-1];
                end
                M_ROR: begin
                    data_d = {data_q[0], data_q[WIDTH-1:1]};
                    s_d    = data_q[0];
                end
                M_LOAD: data_d = p_in;
                M_ASR: begin
                    data_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
                    s_d    = data_q[0];
                end
                M_CLR:   data_d = '0;
                default: data_d = data_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= M_HOLD;
            data_q  <= '0;
            s_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            s_q     <= s_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign d_out = data_q;
    assign s_out = s_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against an arithmetic model.
module tb_univ_shift_reg;

    localparam int unsigned W    = 8;
    localparam int unsigned CW   = 4;
    localparam int unsigned MASK = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [2:0]    mode;
    logic          d_in;
    logic [W-1:0]  p_in;
    logic          start;
    logic [CW-1:0] shamt;
    logic [W-1:0]  d_out;
    logic          s_out;
    logic          busy;
    logic          done;

    int vectors     = 0;
    int miscompares = 0;

    univ_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mode  (mode),
        .d_in  (d_in),
        .p_in  (p_in),
        .start (start),
        .shamt (shamt),
        .d_out (d_out),
        .s_out (s_out),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register value as an integer, burst as steps remaining.
    int unsigned m_val;
    int unsigned m_sout;
    int          m_left;
    int unsigned m_bmode;
    bit          m_done;

    function automatic void m_reset();
        m_val = 0; m_sout = 0; m_left = 0; m_bmode = 0; m_done = 0;
    endfunction

    function automatic void m_step(input int unsigned op, input int unsigned din);
        int unsigned msb = (m_val >> (W - 1)) & 1;
        int unsigned lsb = m_val & 1;
        case (op)
            1: begin m_sout = msb; m_val = ((m_val * 2) + din) & MASK; end
            2: begin m_sout = lsb; m_val = (m_val / 2) + (din << (W - 1)); end
            3: begin m_sout = msb; m_val = ((m_val * 2) + msb) & MASK; end
            4: begin m_sout = lsb; m_val = (m_val / 2) + (lsb << (W - 1)); end
            5: m_val = int'(p_in);
            6: begin m_sout = lsb; m_val = (m_val / 2) + (msb << (W - 1)); end
            7: m_val = 0;
            default: ;
        endcase
    endfunction

    always @(negedge rst_n) m_reset();

    always @(posedge clk) begin
        if (rst_n) begin
            if (m_done) begin
                m_done = 0;
            end else if (m_left > 0) begin
                m_step(m_bmode, int'(d_in));
                m_left--;
                if (m_left == 0) m_done = 1;
            end else if (start) begin
                if (shamt == 0) m_done = 1;
                else begin m_left = int'(shamt); m_bmode = int'(mode); end
            end else if (en) begin
                m_step(int'(mode), int'(d_in));
            end
        end
    end

    // Every-cycle comparison against the model, shortly after the active edge.
    bit cmp_on = 1'b0;
    always @(posedge clk) begin
        #2;
        if (cmp_on) begin
            check("model d_out", int'(d_out), int'(m_val));
            check("model s_out", int'(s_out), int'(m_sout));
            check("model busy",  int'(busy),  int'(m_left > 0));
            check("model done",  int'(done),  int'(m_done));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Wait (bounded) until done is seen at a negedge; returns busy-cycle count.
    task automatic wait_done(input string name, output int busy_cycles);
        bit seen = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin seen = 1'b1; break; end
            if (busy) busy_cycles++;
            tick();
        end
        check({name, " done seen"}, int'(seen), 1);
    endtask

    task automatic load(input logic [W-1:0] v);
        mode = 3'b101; p_in = v; en = 1'b1; start = 1'b0;
        tick();
        en = 1'b0;
    endtask

    initial begin
        int bc;
        int pulses;
        rst_n = 1'b0; en = 1'b0; mode = '0; d_in = 1'b0; p_in = '0;
        start = 1'b0; shamt = '0;
        m_reset();
        tick(); tick();
        check("reset d_out", int'(d_out), 0);
        check("reset busy",  int'(busy), 0);
        rst_n = 1'b1;
        cmp_on = 1'b1;

        // Load then two left shifts with d_in=1
        load(8'hA5);
        check("load A5", int'(d_out), 'hA5);
        mode = 3'b001; d_in = 1'b1; en = 1'b1;
        tick(); tick();
        en = 1'b0;
        check("shl d_out", int'(d_out), 'h97);
        check("shl s_out", int'(s_out), 0);

        // Rotate-left burst of 3
        load(8'h81);
        mode = 3'b011; shamt = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("rol", bc);
        check("rol busy cycles", bc, 3);
        check("rol d_out", int'(d_out), 'h0C);
        check("rol s_out", int'(s_out), 0);
        tick();
        check("rol done width", int'(done), 0);

        // Arithmetic-right burst of 7 with start/mode noise during RUN
        load(8'h80);
        mode = 3'b110; shamt = 4'd7; start = 1'b1;
        tick();
        mode = 3'b111; shamt = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("asr", bc);
        check("asr d_out", int'(d_out), 'hFF);
        pulses = 1;
        for (int i = 0; i < 4; i++) begin tick(); if (done) pulses++; end
        check("asr done pulses", pulses, 1);

        // Zero-length burst
        mode = 3'b111; shamt = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("shamt0 done", int'(done), 1);
        check("shamt0 busy", int'(busy), 0);
        check("shamt0 d_out", int'(d_out), 'hFF);
        tick();
        check("shamt0 done drop", int'(done), 0);

        // start beats en: clear must not happen on the accepting edge
        mode = 3'b111; shamt = 4'd2; start = 1'b1; en = 1'b1;
        tick();
        start = 1'b0; en = 1'b0;
        check("prio busy", int'(busy), 1);
        check("prio d_out", int'(d_out), 'hFF);
        wait_done("prio", bc);
        check("prio cleared", int'(d_out), 0);
        tick();

        // Reset mid-burst: outputs drop immediately, no done afterwards
        load(8'h3C);
        mode = 3'b011; shamt = 4'd10; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("async rst d_out", int'(d_out), 0);
        check("async rst busy",  int'(busy), 0);
        check("async rst done",  int'(done), 0);
        check("async rst s_out", int'(s_out), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post rst busy", int'(busy), 0);
        check("post rst done", int'(done), 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            mode  = 3'($urandom_range(0, 7));
            d_in  = 1'($urandom_range(0, 1));
            p_in  = W'($urandom);
            en    = 1'($urandom_range(0, 1));
            start = ($urandom_range(0, 9) == 0);
            shamt = CW'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            tick();
        end

        cmp_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
